spi_reg_ctrl: RTL
=================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, register address width; SHALL equal command-byte address field width.
REQ-002 Parameter AUTO_INC, default 1, 1 = address post-increments per data byte, 0 = address held.
REQ-003 Parameter STATUS_BYTE, default 8'hA5, byte returned on MISO during the command byte.
REQ-004 Clk  input  1  system clock; all logic on posedge Clk.
REQ-005 Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Trans_Start  input  1  one-cycle pulse, CS asserted (from SPI slave).
REQ-007 Trans_End  input  1  one-cycle pulse, CS deasserted.
REQ-008 Rx_Valid  input  1  one-cycle pulse, received byte ready.
REQ-009 Rx_Data  input  8  received byte, valid with Rx_Valid.
REQ-010 Tx_Valid  output  1  one-cycle pulse loading Tx_Data into SPI slave shift register.
REQ-011 Tx_Data  output  8  next byte to shift out.
REQ-012 Reg_Addr  output  ADDR_W  register bus address.
REQ-013 Reg_Wr_En  output  1  one-cycle write strobe.
REQ-014 Reg_Wr_Data  output  8  write data, valid with Reg_Wr_En.
REQ-015 Reg_Rd_En  output  1  one-cycle read strobe.
REQ-016 Reg_Rd_Data  input  8  read data, valid exactly 1 cycle after Reg_Rd_En.
REQ-017 Busy  output  1  high in any state other than IDLE.
REQ-018 Byte_Cnt  output  16  bytes received in current transaction, command byte included.
REQ-019 Err  output  1  sticky until next Trans_Start; protocol error flag.

Function
REQ-020 States: IDLE, CMD, WR_DATA, RD_FETCH, RD_LOAD, RD_WAIT.
REQ-021 IDLE: Trans_Start -> CMD, same cycle Tx_Valid=1, Tx_Data=STATUS_BYTE, Byte_Cnt cleared, Err cleared.
REQ-022 CMD: Rx_Valid -> latch Reg_Addr=Rx_Data[ADDR_W-1:0]; Rx_Data[7]=0 -> WR_DATA, Rx_Data[7]=1 -> RD_FETCH.
REQ-023 WR_DATA: Rx_Valid at cycle t -> Reg_Wr_En=1, Reg_Wr_Data=Rx_Data at t+1; address increments after strobe when AUTO_INC=1.
REQ-024 RD_FETCH: Reg_Rd_En=1 for one cycle, -> RD_LOAD.
REQ-025 RD_LOAD: Tx_Data=Reg_Rd_Data, Tx_Valid=1 for one cycle, address increments (AUTO_INC=1), -> RD_WAIT; command byte at t gives Tx_Valid at t+3.
REQ-026 RD_WAIT: Rx_Valid (dummy byte) -> RD_FETCH; Rx_Data ignored.
REQ-027 Address wraps 2^ADDR_W-1 -> 0 without error.
REQ-028 Trans_End in any state -> IDLE next cycle; pending strobes for a byte already received still issue, no new ones.
REQ-029 Trans_Start outside IDLE -> Err=1, restart as REQ-021.
REQ-030 Rx_Valid in RD_FETCH or RD_LOAD (host clocking faster than fetch) -> Err=1, byte counted, state unaffected.
REQ-031 Rx_Valid in IDLE ignored, not counted.
REQ-032 Byte_Cnt increments on each counted Rx_Valid, saturates at 16'hFFFF.
REQ-033 Reg_Wr_En and Reg_Rd_En never high in the same cycle.
REQ-034 Simultaneous Trans_End and Rx_Valid: byte processed (write strobe issues), then IDLE.

Reset
REQ-035 Rst_n low: state IDLE, all strobes 0, Tx_Data=0, Reg_Addr=0, Reg_Wr_Data=0, Byte_Cnt=0, Err=0, Busy=0.
REQ-036 Reset mid-transaction abandons it; no strobe issues after Rst_n deasserts until a new Trans_Start.

Structure
REQ-037 State encoding, command bit position (7) and STATUS_BYTE default SHALL live in shared package spi_ctrl_pkg.
REQ-038 Single module, no sub-modules; address counter inline.

Verification
REQ-039 Write burst: Start, bytes 8'h05,8'h11,8'h22 -> Wr_En at addr 5 data 11, addr 6 data 22; Byte_Cnt=3.
REQ-040 Read: regs[0x10]=8'h3C,[0x11]=8'h4D; Start, 8'h90, two dummies -> Tx_Data 8'hA5, 3C, 4D; Rd_En at t+1 after each byte.
REQ-041 Wrap: write cmd 8'h7F, two data bytes -> addresses 7F then 00, Err=0.
REQ-042 Abort: Trans_End after cmd 8'h83 before dummy -> IDLE, exactly one Rd_En, Busy=0.
REQ-043 Overrun: Rx_Valid in RD_FETCH -> Err=1, held until next Trans_Start clears it.
REQ-044 Reset asserted in WR_DATA -> all outputs at reset values, no Wr_En after release.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register-access controller: FSM states,
// command byte layout and the default status byte.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_FETCH,
    ST_RD_LOAD,
    ST_RD_WAIT
  } state_t;

  // Command byte: bit 7 selects read (1) / write (0), low bits carry the address.
  localparam int unsigned CMD_RW_BIT = 7;

  localparam logic [7:0] STATUS_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Bridges an SPI slave byte interface to a simple register bus: one command
// byte (R/W + address) followed by write data or dummy bytes for reads.
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter bit          AUTO_INC    = 1'b1,
  parameter logic [7:0]  STATUS_BYTE = STATUS_BYTE_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Trans_Start,
  input  logic              Trans_End,
  input  logic              Rx_Valid,
  input  logic [7:0]        Rx_Data,
  output logic              Tx_Valid,
  output logic [7:0]        Tx_Data,
  output logic [ADDR_W-1:0] Reg_Addr,
  output logic              Reg_Wr_En,
  output logic [7:0]        Reg_Wr_Data,
  output logic              Reg_Rd_En,
  input  logic [7:0]        Reg_Rd_Data,
  output logic              Busy,
  output logic [15:0]       Byte_Cnt,
  output logic              Err
);

  state_t     state, next_state;
  logic       tx_load;
  logic [7:0] tx_byte;
  logic       err_set;
  logic       cnt_inc;
  logic       cmd_latch;
  logic       wr_pulse;
  logic       rd_inc;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Byte handling is decided first; Trans_End then Trans_Start override only
  // the state transition, so a byte arriving with Trans_End still strobes.
  always_comb begin
    next_state = state;
    tx_load    = 1'b0;
    tx_byte    = '0;
    err_set    = 1'b0;
    cnt_inc    = Rx_Valid && (state != ST_IDLE);
    cmd_latch  = 1'b0;
    wr_pulse   = 1'b0;
    rd_inc     = 1'b0;

    case (state)
      ST_IDLE: ;
      ST_CMD: begin
        if (Rx_Valid) begin
          cmd_latch  = 1'b1;
          next_state = Rx_Data[CMD_RW_BIT] ? ST_RD_FETCH : ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (Rx_Valid) wr_pulse = 1'b1;
      end
      ST_RD_FETCH: begin
        next_state = ST_RD_LOAD;
        if (Rx_Valid) err_set = 1'b1;
      end
      ST_RD_LOAD: begin
        tx_load    = 1'b1;
        tx_byte    = Reg_Rd_Data;
        rd_inc     = 1'b1;
        next_state = ST_RD_WAIT;
        if (Rx_Valid) err_set = 1'b1;
      end
      ST_RD_WAIT: begin
        if (Rx_Valid) next_state = ST_RD_FETCH;
      end
      default: next_state = ST_IDLE;
    endcase

    if (Trans_End) next_state = ST_IDLE;

    if (Trans_Start) begin
      next_state = ST_CMD;
      tx_load    = 1'b1;
      tx_byte    = STATUS_BYTE;
      if (state != ST_IDLE) err_set = 1'b1;
    end
  end

  assign Reg_Rd_En = (state == ST_RD_FETCH);
  assign Busy      = (state != ST_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Tx_Valid    <= 1'b0;
      Tx_Data     <= '0;
      Reg_Addr    <= '0;
      Reg_Wr_En   <= 1'b0;
      Reg_Wr_Data <= '0;
      Byte_Cnt    <= '0;
      Err         <= 1'b0;
    end else begin
      Tx_Valid  <= tx_load;
      Reg_Wr_En <= wr_pulse;
      if (tx_load)  Tx_Data     <= tx_byte;
      if (wr_pulse) Reg_Wr_Data <= Rx_Data;

      // Write address advances at the end of its strobe cycle, read address
      // at the end of the load cycle; both wrap naturally at 2^ADDR_W.
      if (cmd_latch)
        Reg_Addr <= Rx_Data[ADDR_W-1:0];
      else if (AUTO_INC && (Reg_Wr_En || rd_inc))
        Reg_Addr <= Reg_Addr + 1'b1;

      if (Trans_Start)
        Byte_Cnt <= '0;
      else if (cnt_inc && (Byte_Cnt != '1))
        Byte_Cnt <= Byte_Cnt + 16'd1;

      if (err_set)          Err <= 1'b1;
      else if (Trans_Start) Err <= 1'b0;
    end
  end

endmodule
